// File: rtl/mem_dstb_pkg.sv
// mem_dstb_pkg: response codes, FSM states and default CLINT/memory windows for mem_dstb_n
package mem_dstb_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [63:0] DEF_CLINT_BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] DEF_CLINT_MASK = 64'hFFFF_FFFF_FFFF_0000;
  localparam logic [63:0] DEF_MEM_BASE   = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_MEM_MASK   = 64'hFFFF_FFFF_8000_0000;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_t;
endpackage

// File: rtl/mem_dstb_dec.sv
// mem_dstb_dec: combinational address decoder, one-hot lowest-index window hit plus miss flag
//   i_addr : request address
//   o_hit  : one-hot hit, lowest hitting channel only
//   o_miss : no channel window matches
module mem_dstb_dec #(
  parameter int N_CH = 2,
  parameter int ADDR_W = 64,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE = '0,
  parameter logic [N_CH*ADDR_W-1:0] CH_MASK = '0
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [N_CH-1:0]   o_hit,
  output logic              o_miss
);
  always_comb begin
    o_hit = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if ((i_addr & CH_MASK[i*ADDR_W +: ADDR_W]) == CH_BASE[i*ADDR_W +: ADDR_W]) o_hit = N_CH'(1) << i;
  end
  assign o_miss = ~|o_hit;
endmodule

// File: rtl/mem_dstb_n.sv
// mem_dstb_n: N-channel LSU data-side request distributor with decode error and optional timeout
//   clk, rst_n            : clock, synchronous active-low reset
//   up_*                  : LSU request (valid held until up_ready) and completion response
//   dn_valid / dn_ready   : per-channel request valid and completion pulse
//   dn_addr..dn_req       : registered request bus shared by all channels
//   dn_data_read, dn_resp : per-channel read data and response
//   Optional MEM_DSTB_TIMEOUT_EN: SLVERR after TIMEOUT_CYCLES BUSY cycles without dn_ready[sel]
module mem_dstb_n
  import mem_dstb_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter logic [N_CH*ADDR_W-1:0] CH_BASE = {DEF_MEM_BASE, DEF_CLINT_BASE},
  parameter logic [N_CH*ADDR_W-1:0] CH_MASK = {DEF_MEM_MASK, DEF_CLINT_MASK},
  parameter logic [N_CH-1:0] SKIP_MASK = 2'b01,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [ADDR_W-1:0]      up_addr,
  input  logic [DATA_W-1:0]      up_data_write,
  input  logic [1:0]             up_size,
  input  logic                   up_req,
  output logic [DATA_W-1:0]      up_data_read,
  output logic [1:0]             up_resp,
  output logic                   up_skip,
  output logic [N_CH-1:0]        dn_valid,
  input  logic [N_CH-1:0]        dn_ready,
  output logic [ADDR_W-1:0]      dn_addr,
  output logic [DATA_W-1:0]      dn_data_write,
  output logic [1:0]             dn_size,
  output logic                   dn_req,
  input  logic [N_CH*DATA_W-1:0] dn_data_read,
  input  logic [N_CH*2-1:0]      dn_resp
);
  state_t r_state;
  logic [N_CH-1:0] r_sel, w_hit;
  logic r_skip, w_miss, w_done, w_tmo;
  logic [DATA_W-1:0] w_rd;
  logic [1:0] w_rsp;
  mem_dstb_dec #(.N_CH(N_CH), .ADDR_W(ADDR_W), .CH_BASE(CH_BASE), .CH_MASK(CH_MASK)) u_dec (
    .i_addr(up_addr), .o_hit(w_hit), .o_miss(w_miss)
  );
  assign w_done = r_state == ST_BUSY && |(dn_ready & r_sel);
`ifdef MEM_DSTB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n || r_state != ST_BUSY) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  // a slave completion in the timeout cycle takes priority over the timeout
  assign w_tmo = r_state == ST_BUSY && !w_done && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_tmo = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel <= '0;
      r_skip <= 1'b0;
      dn_valid <= '0;
      dn_addr <= '0;
      dn_data_write <= '0;
      dn_size <= '0;
      dn_req <= 1'b0;
    end else case (r_state)
      ST_IDLE: if (up_valid) begin
        if (w_miss) r_state <= ST_ERR;
        else begin
          r_state <= ST_BUSY;
          r_sel <= w_hit;
          r_skip <= |(w_hit & SKIP_MASK);
          dn_valid <= w_hit;
          dn_addr <= up_addr;
          dn_data_write <= up_data_write;
          dn_size <= up_size;
          dn_req <= up_req;
        end
      end
      ST_BUSY: if (w_done || w_tmo) begin
        r_state <= ST_IDLE;
        dn_valid <= '0;
      end
      default: r_state <= ST_IDLE;
    endcase
  always_comb begin
    w_rd = '0;
    w_rsp = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rd = w_rd | (r_sel[i] ? dn_data_read[i*DATA_W +: DATA_W] : '0);
      w_rsp = w_rsp | (r_sel[i] ? dn_resp[i*2 +: 2] : 2'b00);
    end
  end
  assign up_ready = r_state == ST_ERR || w_done || w_tmo;
  assign up_data_read = w_done ? w_rd : '0;
  assign up_resp = w_done ? w_rsp : r_state == ST_ERR ? RESP_DECERR : w_tmo ? RESP_SLVERR : RESP_OKAY;
  assign up_skip = w_done & r_skip;
endmodule

// File: doc/mem_dstb_n.md
# mem_dstb_n

Parametrised N-channel data-side request distributor between the LSU data port and its downstream targets: CLINT, main memory bridge, and future MMIO. Decodes each request against per-channel base/mask windows and latches the route and request fields for the whole transaction. Returns a decode-error response for unmapped addresses and, optionally, a timeout error for stalled targets. Emits a difftest skip flag for channels marked as non-comparable.

## Interface
- `N_CH`, 2: number of downstream channels (1..8).
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width.
- `CH_BASE`, {0x8000_0000, 0x0200_0000}: packed `N_CH*ADDR_W` window bases; channel i occupies slice i.
- `CH_MASK`, {0xFFFF_FFFF_8000_0000, 0xFFFF_FFFF_FFFF_0000}: packed `N_CH*ADDR_W` window masks.
- `SKIP_MASK`, 2'b01: bit i set means channel i accesses raise `up_skip`.
- `TIMEOUT_CYCLES`, 256: BUSY cycles before the timeout error. Used only with the macro.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `up_valid` in 1: request valid from the LSU. Held until `up_ready`.
- `up_ready` out 1: one-cycle completion pulse.
- `up_addr` in ADDR_W: request address.
- `up_data_write` in DATA_W: write data.
- `up_size` in 2: access size.
- `up_req` in 1: 1 = write, 0 = read.
- `up_data_read` out DATA_W: read data. Valid only with `up_ready`.
- `up_resp` out 2: response code. Valid only with `up_ready`.
- `up_skip` out 1: difftest skip flag, asserted with `up_ready`.
- `dn_valid` out N_CH: per-channel request valid.
- `dn_ready` in N_CH: per-channel completion pulse.
- `dn_addr`, `dn_data_write`, `dn_size`, `dn_req` out: single registered bus shared by all channels.
- `dn_data_read` in N_CH*DATA_W: per-channel read data.
- `dn_resp` in N_CH*2: per-channel response.

## Operation
- Decode: hit[i] = (`up_addr` & mask_i) == base_i. The lowest hitting index wins.
- FSM has three states: IDLE, BUSY, ERR.
- IDLE, `up_valid`=1, some channel hits:
  - Register addr, data, size and req.
  - Register the one-hot select and the skip bit.
  - Go to BUSY.
- IDLE, `up_valid`=1, no channel hits: go to ERR.
- BUSY:
  - `dn_valid[sel]`=1; all other `dn_valid` bits are 0.
  - When `dn_ready[sel]`=1: `up_ready`=1 in the same cycle, `up_data_read`/`up_resp` pass combinationally from channel sel, `up_skip`=registered skip bit, go to IDLE.
  - `dn_ready` on any unselected channel is ignored.
- ERR: `up_ready`=1, `up_resp`=2'b11, `up_data_read`=0, `up_skip`=0, go to IDLE.
- Request fields are latched at acceptance. Changes on `up_addr`/`up_data_write` during BUSY have no effect.
- Master contract: `up_valid` is held until `up_ready`. A `up_valid` still high in the cycle after `up_ready` is a new request.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - State becomes IDLE.
  - Registered `dn_*` fields and `dn_valid` go to 0.
  - `up_ready`=0, `up_resp`=0, `up_data_read`=0, `up_skip`=0.
  - Reset mid-BUSY abandons the transaction; a late `dn_ready` after reset is ignored.
- Latency:
  - Request to `dn_valid`: 1 cycle.
  - Mapped completion: `dn_ready` cycle, zero added latency.
  - Unmapped completion: `up_ready` 1 cycle after acceptance.
- Throughput: one transaction per two cycles minimum (IDLE→BUSY→IDLE).
- `dn_valid` deasserts in the cycle after `dn_ready`.
- `up_ready` is never asserted in IDLE.

## Configuration
- `MEM_DSTB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no `dn_ready[sel]`: `up_ready`=1, `up_resp`=2'b10, `up_data_read`=0, `up_skip`=0, `dn_valid` drops next cycle, go to IDLE.
  - If `dn_ready[sel]` arrives in the same cycle as the timeout, the slave response wins.
- Macro undefined: no counter. BUSY waits indefinitely.

## Structure
- Shared package or defines holds:
  - Response codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state encoding.
  - Default CLINT and memory base/mask constants.
- One sub-module: `mem_dstb_dec`, purely combinational, maps addr to a one-hot hit vector plus a `miss` flag.

## Test plan
- Read to 0x0200_BFF8 with `dn_ready[0]` 3 cycles after `dn_valid[0]` and data 0x1234:
  - `dn_valid`=2'b01 one cycle after acceptance.
  - `up_ready` pulses with `up_data_read`=0x1234, `up_resp`=0, `up_skip`=1.
- Write to 0x8000_1000, data 0xDEAD_BEEF, `up_req`=1, then `up_addr` changed during BUSY:
  - `dn_valid`=2'b10 and `dn_addr` stays 0x8000_1000.
  - `up_skip`=0 at completion.
- Access to 0x1000_0000 (unmapped): `up_ready` 1 cycle after acceptance with `up_resp`=2'b11, `up_data_read`=0, and no `dn_valid` ever.
- Spurious `dn_ready[0]` during a BUSY channel-1 transaction: ignored. Completion only on `dn_ready[1]`.
- Reset asserted mid-BUSY, then a late `dn_ready`: all outputs 0 next cycle, state IDLE, no `up_ready` produced.
- With `MEM_DSTB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, slave silent:
  - `up_ready` with `up_resp`=2'b10 in the 16th BUSY cycle.
  - Repeat with `dn_ready` in that same cycle: `up_resp`=slave value.
